prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter START_ADDR, default 32'h00000000, is the fetch address after reset.
REQ-002 Parameter DEPTH, default 4, is the queue entries and max outstanding requests (power of 2, >=2).
REQ-003 Parameter TAG_W, default 4, is the epoch tag width.
REQ-004 clk  in  1  the single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 i_address  out  32  instruction fetch address.
REQ-007 i_req  out  1  fetch request valid.
REQ-008 i_gnt  in  1  memory accepts the request this cycle.
REQ-009 i_valid  in  1  in-order response valid.
REQ-010 instruction  in  32  response data, qualified by i_valid.
REQ-011 jump  in  1  redirect request from retire.
REQ-012 new_pc  in  32  redirect target, qualified by jump.
REQ-013 stall  in  1  decode holds the current output.
REQ-014 out_valid  out  1  IR/pc_out/tag_out hold a valid instruction.
REQ-015 IR  out  32  instruction word.
REQ-016 pc_out  out  32  address of IR.
REQ-017 tag_out  out  TAG_W  epoch of IR.

Function
REQ-018 The block SHALL assert i_req when no jump is present and (queue occupancy + outstanding) < DEPTH.
REQ-019 On i_req&i_gnt, the block SHALL record i_address as outstanding and advance i_address by 4 in the next cycle.
REQ-020 While i_req=1 and i_gnt=0, the block SHALL hold i_address stable.
REQ-021 Each i_valid SHALL retire the oldest outstanding request; non-discarded responses SHALL be written to the queue with their address and the current epoch.
REQ-022 Out_valid SHALL equal "queue non-empty"; a response written in cycle N SHALL be visible at the outputs no earlier than cycle N+1.
REQ-023 The head SHALL be popped on out_valid&!stall; with stall=1, outputs SHALL hold.
REQ-024 Simultaneous push and pop SHALL be allowed when the queue is full or empty.
REQ-025 On jump, the block SHALL flush the queue (out_valid=0 next cycle) and deassert i_req in that cycle.
REQ-026 On jump, the block SHALL load i_address with {new_pc[31:2],2'b00} and increment the epoch modulo 2^TAG_W.
REQ-027 On jump, a discard counter SHALL load the outstanding count, excluding any response arriving in the jump cycle.
REQ-028 Any response arriving in the jump cycle SHALL be dropped.
REQ-029 While the discard counter is non-zero, each i_valid SHALL be dropped and decrement the counter.
REQ-030 New-epoch requests SHALL be allowed while discarding.
REQ-031 Jump SHALL take priority over stall, push and pop in the same cycle.
REQ-032 A jump during discard SHALL reload the counter with the total outstanding count.
REQ-033 Outstanding count SHALL never exceed DEPTH, and i_valid with zero outstanding SHALL be ignored.

Reset
REQ-034 While reset=0 at a clock edge: i_address=START_ADDR, i_req=0, out_valid=0, IR=0, pc_out=0, tag_out=0, epoch=0, queue empty, outstanding=0, discard=0.
REQ-035 Reset SHALL abandon in-flight requests; the first i_req SHALL occur in the first cycle after reset returns to 1.

Structure
REQ-036 The shared package SHALL hold the default DEPTH/TAG_W constants and the queue entry struct {pc, instruction, tag}.
REQ-037 Storage SHALL be a sub-module fetch_fifo (DEPTH entries, pointer wrap, full/empty, simultaneous push/pop).

Verification
REQ-038 Reset release with i_gnt=1 and 1-cycle i_valid SHALL yield i_address 0,4,8,12 on i_req, and IR/pc_out pairs at PC 0,4,8 with tag_out=0.
REQ-039 With stall=1 for 10 cycles, DEPTH=4: exactly 4 grants, then i_req=0 and outputs frozen; stall release SHALL resume with no lost or duplicated PCs.
REQ-040 jump with new_pc=32'h103 and 2 outstanding: next i_address=32'h100, tag_out=1, the 2 old responses dropped, first out PC 32'h100.
REQ-041 jump coinciding with i_valid and stall=1: response dropped, out_valid=0 next cycle.
REQ-042 16 jumps at TAG_W=4: tag_out SHALL wrap 15->0.
REQ-043 reset=0 mid-stream with 3 outstanding: all outputs at reset values next cycle, and fetch restarts at START_ADDR.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   DEFAULT_DEPTH / DEFAULT_TAG_W : default parameter values for the top.
//   MAX_TAG_W                     : storage width of the tag field; the top
//                                   zero-extends its TAG_W-bit epoch into it,
//                                   so TAG_W must not exceed MAX_TAG_W.
//   pq_entry_t                    : one queue entry {pc, instruction, tag}.
package prefetch_queue_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_TAG_W = 4;
  localparam int MAX_TAG_W     = 16;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          instruction;
    logic [MAX_TAG_W-1:0] tag;
  } pq_entry_t;

endpackage

// File: rtl/prefetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of pq_entry_t.
//   clk, reset (sync, active-low)
//   i_flush          : empties the buffer (priority over push/pop)
//   i_push/i_data    : write one entry (accepted when not full, or when
//                      a pop happens in the same cycle)
//   i_pop            : drop the head entry (ignored when empty)
//   o_head           : current head entry (valid when !o_empty)
//   o_empty/o_full   : occupancy flags
//   o_count          : number of stored entries, 0..DEPTH
module fetch_fifo
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  pq_entry_t              i_data,
  input  logic                   i_pop,
  output pq_entry_t              o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  pq_entry_t      r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_pop;
  logic           w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full buffer can still take a push when the head leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: sequential instruction prefetcher with an in-order
// response queue and epoch-tagged redirect handling.
//   clk, reset (sync, active-low)
//   Memory side : i_address/i_req out, i_gnt in, i_valid/instruction in.
//   Redirect    : jump, new_pc (word aligned internally).
//   Decode side : stall in; out_valid, IR, pc_out, tag_out out.
// Handshakes: a request transfers on a cycle with i_req=1 and i_gnt=1;
// i_address is held while i_req=1 and i_gnt=0. Responses return in request
// order, one per i_valid cycle, with no back-pressure. The decode side
// consumes the head on out_valid=1 and stall=0; stall=1 holds the outputs.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = DEFAULT_DEPTH,
  parameter int          TAG_W      = DEFAULT_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      i_address,
  output logic             i_req,
  input  logic             i_gnt,
  input  logic             i_valid,
  input  logic [31:0]      instruction,
  input  logic             jump,
  input  logic [31:0]      new_pc,
  input  logic             stall,
  output logic             out_valid,
  output logic [31:0]      IR,
  output logic [31:0]      pc_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int             CW       = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    LP_DEPTH = (CW+1)'(DEPTH);

  logic [31:0]      r_addr;      // next request address
  logic [31:0]      r_resp_pc;   // address of the oldest live-epoch request
  logic [TAG_W-1:0] r_epoch;
  logic [CW-1:0]    r_out_cnt;   // requests granted but not yet answered
  logic [CW-1:0]    r_discard;   // stale responses still to be dropped

  logic             w_grant;
  logic             w_retire;
  logic             w_push;
  logic             w_pop;
  logic [CW:0]      w_inflight;
  logic [CW-1:0]    w_fifo_count;
  logic             w_empty;
  logic             w_full;
  logic [31:0]      w_jump_pc;
  pq_entry_t        w_push_data;
  pq_entry_t        w_head;
  logic             w_unused;

  // Queue slots plus in-flight requests bound the number of responses that
  // can land, so a push never finds the queue full.
  assign w_inflight = {1'b0, w_fifo_count} + {1'b0, r_out_cnt};
  assign i_req      = reset && !jump && (w_inflight < LP_DEPTH);
  assign i_address  = r_addr;
  assign w_grant    = i_req && i_gnt;
  // A response with nothing outstanding is spurious and ignored entirely.
  assign w_retire   = i_valid && (r_out_cnt != '0);
  assign w_push     = w_retire && !jump && (r_discard == '0) && (!w_full || w_pop);
  assign w_pop      = !w_empty && !stall && !jump;
  assign w_jump_pc  = {new_pc[31:2], 2'b00};

  // Responses of the live epoch arrive in address order, so the entry pc is
  // tracked by a counter instead of a per-request address store.
  always_comb begin
    w_push_data             = '0;
    w_push_data.pc          = r_resp_pc;
    w_push_data.instruction = instruction;
    w_push_data.tag         = MAX_TAG_W'(r_epoch);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr    <= START_ADDR;
      r_resp_pc <= START_ADDR;
      r_epoch   <= '0;
      r_out_cnt <= '0;
      r_discard <= '0;
    end else begin
      r_out_cnt <= r_out_cnt + CW'(w_grant) - CW'(w_retire);
      if (jump) begin
        r_addr    <= w_jump_pc;
        r_resp_pc <= w_jump_pc;
        r_epoch   <= r_epoch + TAG_W'(1);
        // Everything still in flight belongs to the old epoch; a response
        // landing this very cycle is already dropped and not counted.
        r_discard <= r_out_cnt - CW'(w_retire);
      end else begin
        if (w_grant) r_addr <= r_addr + 32'd4;
        if (w_retire) begin
          if (r_discard != '0) r_discard <= r_discard - CW'(1);
          else                 r_resp_pc <= r_resp_pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (jump),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_fifo_count)
  );

  // Outputs read as zero whenever the queue is empty.
  assign out_valid = !w_empty;
  assign IR        = w_empty ? 32'd0 : w_head.instruction;
  assign pc_out    = w_empty ? 32'd0 : w_head.pc;
  assign tag_out   = w_empty ? '0    : w_head.tag[TAG_W-1:0];

  // Upper tag bits beyond TAG_W are always zero.
  assign w_unused = ^w_head.tag;

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

  localparam int          DEPTH = 4;
  localparam int          TAG_W = 4;
  localparam logic [31:0] START = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      i_address;
  logic             i_req;
  logic             i_gnt;
  logic             i_valid;
  logic [31:0]      instruction;
  logic             jump;
  logic [31:0]      new_pc;
  logic             stall;
  logic             out_valid;
  logic [31:0]      IR;
  logic [31:0]      pc_out;
  logic [TAG_W-1:0] tag_out;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  prefetch_queue #(
    .START_ADDR (START),
    .DEPTH      (DEPTH),
    .TAG_W      (TAG_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_address   (i_address),
    .i_req       (i_req),
    .i_gnt       (i_gnt),
    .i_valid     (i_valid),
    .instruction (instruction),
    .jump        (jump),
    .new_pc      (new_pc),
    .stall       (stall),
    .out_valid   (out_valid),
    .IR          (IR),
    .pc_out      (pc_out),
    .tag_out     (tag_out)
  );

  // ---------------- scoreboard state ----------------
  int               checks = 0;
  int               errors = 0;
  int               grants = 0;
  int               pops   = 0;
  bit               resp_en = 1'b0;
  bit               sb_en   = 1'b0;
  logic [TAG_W-1:0] exp_tag;
  logic [31:0]      gq[$];     // granted addresses awaiting a response
  logic [31:0]      exp_q[$];  // expected pc sequence at the output

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        vld;
    logic [31:0] ins;
    logic        stl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [3:0]  e_tag;
  } vec_t;

  vec_t vt[10];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_resp();
    if (resp_en && gq.size() != 0) begin
      i_valid     = 1'b1;
      instruction = data_of(gq.pop_front());
    end else begin
      i_valid     = 1'b0;
      instruction = 32'd0;
    end
  endtask

  task automatic cycle();
    logic [31:0] e;
    drive_resp();
    #1;
    if (i_req && i_gnt) begin
      gq.push_back(i_address);
      grants++;
    end
    if (sb_en && out_valid && !stall && !jump) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra_pop actual=%h expected=none", pc_out);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", pc_out, e);
        chk("sb_ir", IR, data_of(e));
        chk("sb_tag", 32'(tag_out), 32'(exp_tag));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [31:0] tgt);
    jump   = 1'b1;
    new_pc = tgt;
    drive_resp();
    #1;
    chk("jump_req", 32'(i_req), 0);
    @(posedge clk);
    #1;
    jump    = 1'b0;
    new_pc  = 32'd0;
    exp_tag = exp_tag + 4'd1;
    chk("jump_ov", 32'(out_valid), 0);
    chk("jump_addr", i_address, {tgt[31:2], 2'b00});
  endtask

  task automatic do_reset();
    reset = 1'b0; i_gnt = 1'b0; i_valid = 1'b0; instruction = 32'd0;
    jump = 1'b0; new_pc = 32'd0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    gq.delete();
    exp_q.delete();
    exp_tag = '0;
    grants  = 0;
    pops    = 0;
  endtask

  task automatic fill_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  initial begin
    bit          found;
    logic [31:0] tgt;

    //        rst  gnt  vld  ins           stl  req  addr   ov   pc     ir            tag
    vt[0] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'd0, 1'b0,32'd0, 32'h0,        4'd0};
    vt[1] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b1,32'd0, 1'b0,32'd0, 32'h0,        4'd0};
    vt[2] = '{1'b1,1'b1,1'b1,32'hA5A50000, 1'b0,1'b1,32'd4, 1'b0,32'd0, 32'h0,        4'd0};
    vt[3] = '{1'b1,1'b1,1'b1,32'hA5A50004, 1'b0,1'b1,32'd8, 1'b1,32'd0, 32'hA5A50000, 4'd0};
    vt[4] = '{1'b1,1'b1,1'b1,32'hA5A50008, 1'b0,1'b1,32'd12,1'b1,32'd4, 32'hA5A50004, 4'd0};
    vt[5] = '{1'b1,1'b0,1'b1,32'hA5A5000C, 1'b0,1'b1,32'd16,1'b1,32'd8, 32'hA5A50008, 4'd0};
    vt[6] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'd16,1'b1,32'd12,32'hA5A5000C, 4'd0};
    vt[7] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'd16,1'b0,32'd0, 32'h0,        4'd0};
    vt[8] = '{1'b1,1'b0,1'b1,32'hDEADBEEF, 1'b1,1'b1,32'd16,1'b0,32'd0, 32'h0,        4'd0};
    vt[9] = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,32'd16,1'b0,32'd0, 32'h0,        4'd0};

    // Table: reset state, first fetches, grant hold, spurious response.
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      reset = vt[i].rst; i_gnt = vt[i].gnt; i_valid = vt[i].vld;
      instruction = vt[i].ins; stall = vt[i].stl; jump = 1'b0; new_pc = 32'd0;
      #1;
      chk($sformatf("tbl%0d_req", i),  32'(i_req),     32'(vt[i].e_req));
      chk($sformatf("tbl%0d_addr", i), i_address,      vt[i].e_addr);
      chk($sformatf("tbl%0d_ov", i),   32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("tbl%0d_pc", i),   pc_out,         vt[i].e_pc);
      chk($sformatf("tbl%0d_ir", i),   IR,             vt[i].e_ir);
      chk($sformatf("tbl%0d_tag", i),  32'(tag_out),   32'(vt[i].e_tag));
      @(posedge clk);
      #1;
    end

    // Stall for 10 cycles: DEPTH grants, then frozen; release resumes in order.
    do_reset();
    stall = 1'b1; i_gnt = 1'b1; resp_en = 1'b1;
    repeat (10) cycle();
    chk("stall_grants", grants, DEPTH);
    chk("stall_req", 32'(i_req), 0);
    chk("stall_ov", 32'(out_valid), 1);
    chk("stall_pc", pc_out, 32'h0);
    chk("stall_ir", IR, data_of(32'h0));
    stall = 1'b0;
    fill_exp(32'h0, 64);
    sb_en = 1'b1;
    repeat (16) cycle();
    sb_en = 1'b0;
    chk("stall_resume_pops", 32'(pops >= 12), 1);

    // Jump to 0x103 with two requests outstanding.
    do_reset();
    i_gnt = 1'b1; resp_en = 1'b0;
    repeat (2) cycle();
    do_jump(32'h103);
    chk("j103_addr", i_address, 32'h100);
    resp_en = 1'b1;
    fill_exp(32'h100, 32);
    sb_en = 1'b1;
    pops  = 0;
    repeat (12) cycle();
    sb_en = 1'b0;
    chk("j103_tag", 32'(exp_tag), 1);
    chk("j103_pops", 32'(pops >= 4), 1);

    // Jump in the same cycle as a response, with stall held.
    do_reset();
    stall = 1'b1; i_gnt = 1'b1; resp_en = 1'b1;
    repeat (3) cycle();
    chk("jv_ov_before", 32'(out_valid), 1);
    do_jump(32'h200);
    stall = 1'b0;
    fill_exp(32'h200, 32);
    sb_en = 1'b1;
    pops  = 0;
    repeat (10) cycle();
    sb_en = 1'b0;
    chk("jv_pops", 32'(pops >= 3), 1);

    // Sixteen jumps: epoch wraps back to zero.
    do_reset();
    i_gnt = 1'b1; resp_en = 1'b1;
    repeat (3) cycle();
    for (int k = 0; k < 16; k++) begin
      tgt = 32'h1000 + 32'(k * 64);
      do_jump(tgt);
      found = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (out_valid) begin
          found = 1'b1;
          break;
        end
        cycle();
      end
      chk("wrap_seen", 32'(found), 1);
      chk("wrap_tag", 32'(tag_out), 32'(exp_tag));
      chk("wrap_pc", pc_out, tgt);
      if (k == 14) chk("wrap_tag15", 32'(tag_out), 15);
    end
    chk("wrap_tag0", 32'(tag_out), 0);

    // Reset mid-stream with three requests outstanding.
    do_reset();
    i_gnt = 1'b1; resp_en = 1'b1; stall = 1'b1;
    do_jump(32'h300);
    repeat (2) cycle();
    resp_en = 1'b0;
    repeat (2) cycle();
    chk("mr_ov_before", 32'(out_valid), 1);
    chk("mr_tag_before", 32'(tag_out), 1);
    reset = 1'b0; i_valid = 1'b0; instruction = 32'd0;
    #1;
    chk("mr_req_in_reset", 32'(i_req), 0);
    @(posedge clk);
    #1;
    chk("mr_ov", 32'(out_valid), 0);
    chk("mr_ir", IR, 32'd0);
    chk("mr_pc", pc_out, 32'd0);
    chk("mr_tag", 32'(tag_out), 0);
    chk("mr_addr", i_address, START);
    chk("mr_req", 32'(i_req), 0);
    reset = 1'b1;
    gq.delete();
    exp_q.delete();
    exp_tag = '0;
    resp_en = 1'b1; stall = 1'b0;
    fill_exp(START, 32);
    pops  = 0;
    sb_en = 1'b1;
    repeat (10) cycle();
    sb_en = 1'b0;
    chk("mr_restart_pops", 32'(pops >= 3), 1);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
